// File: rtl/bram_lsu_pkg.sv
// Shared definitions for the BRAM load/store initiator: access-size
// encodings, FSM state encoding and the byte-lane count of the data path.
package bram_lsu_pkg;

  localparam int LANES = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  // Byte-lane index of the low half-word bits; halves only look at a[1].
  function automatic logic [1:0] half_lane(input logic [1:0] addr_lo);
    return {addr_lo[1], 1'b0};
  endfunction

endpackage

// File: rtl/bram_lsu_master_if.sv
// Bundle of the core request/response handshake and the BRAM port signals.
// The master modport is the load/store initiator's view; the slave modport
// is the combined core + BRAM side.
interface bram_lsu_master_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int XLEN       = 32
);
  import bram_lsu_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [XLEN-1:0]       req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [XLEN-1:0]       rsp_rdata;
  logic                  rsp_err;

  logic                  bram_en;
  logic [LANES-1:0]      bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [XLEN-1:0]       bram_din;
  logic                  bram_regce;
  logic                  bram_rst;
  logic [XLEN-1:0]       bram_dout;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output bram_en, bram_we, bram_addr, bram_din, bram_regce, bram_rst,
    input  bram_dout
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  bram_en, bram_we, bram_addr, bram_din, bram_regce, bram_rst,
    output bram_dout
  );

endinterface

// File: rtl/bram_lsu_align.sv
// Combinational byte-lane logic for the BRAM load/store initiator:
// store data replication and write-enable generation, load data extraction
// with sign/zero extension, and misalignment detection.
// Optional feature macro: LSU_MISALIGN_EXC_EN (flag misaligned half/word
// accesses); when undefined the misalign output is constant 0 and the
// offending low address bits are simply ignored.
module bram_lsu_align
  import bram_lsu_pkg::*;
(
  input  logic [1:0]       req_size,
  input  logic [1:0]       req_addr_lo,
  input  logic [31:0]      req_wdata,
  output logic [LANES-1:0] st_we,
  output logic [31:0]      st_din,
  output logic             misalign,
  input  logic [1:0]       ld_size,
  input  logic [1:0]       ld_addr_lo,
  input  logic             ld_unsigned,
  input  logic [31:0]      ld_dout,
  output logic [31:0]      ld_data
);

  logic [31:0] ld_shifted;

  // Steer store data onto every lane and enable only the addressed lanes.
  always_comb begin
    st_we  = '0;
    st_din = '0;
    case (req_size)
      SIZE_BYTE: begin
        st_we  = 4'b0001 << req_addr_lo;
        st_din = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        st_we  = 4'b0011 << half_lane(req_addr_lo);
        st_din = {2{req_wdata[15:0]}};
      end
      default: begin
        st_we  = 4'b1111;
        st_din = req_wdata;
      end
    endcase
  end

  // Shift the addressed bytes down to bit 0, then extend to a full word.
  always_comb begin
    ld_shifted = '0;
    ld_data    = '0;
    case (ld_size)
      SIZE_BYTE: begin
        ld_shifted = ld_dout >> {ld_addr_lo, 3'b000};
        ld_data    = ld_unsigned ? {24'h000000, ld_shifted[7:0]}
                                 : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      end
      SIZE_HALF: begin
        ld_shifted = ld_dout >> {ld_addr_lo[1], 4'b0000};
        ld_data    = ld_unsigned ? {16'h0000, ld_shifted[15:0]}
                                 : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      end
      default: begin
        ld_shifted = ld_dout;
        ld_data    = ld_dout;
      end
    endcase
  end

`ifdef LSU_MISALIGN_EXC_EN
  // Halves must be 2-byte aligned and words 4-byte aligned.
  always_comb begin
    misalign = 1'b0;
    case (req_size)
      SIZE_BYTE: misalign = 1'b0;
      SIZE_HALF: misalign = req_addr_lo[0];
      default:   misalign = |req_addr_lo;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/bram_lsu_master.sv
// Load/store initiator for one port of a byte-write BRAM. Accepts one
// request at a time from the core, issues a single registered BRAM access,
// waits out the BRAM read latency and returns extended load data.
// Optional feature macro: LSU_MISALIGN_EXC_EN (misaligned half/word
// accesses skip the BRAM and respond immediately with rsp_err set).
module bram_lsu_master
  import bram_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH   = 15,
  parameter int READ_LATENCY = 1,
  parameter int XLEN         = 32
) (
  input  logic               clka,
  input  logic               rsta_n,
  bram_lsu_master_if.master  bus
);

  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

  lsu_state_e            state;
  logic [1:0]            wait_cnt;
  logic                  req_ready_q;
  logic                  is_store;
  logic [1:0]            ld_size_q;
  logic [1:0]            ld_addr_lo_q;
  logic                  ld_unsigned_q;

  logic                  rsp_valid_q;
  logic [XLEN-1:0]       rsp_rdata_q;
  logic                  rsp_err_q;

  logic                  bram_en_q;
  logic [LANES-1:0]      bram_we_q;
  logic [ADDR_WIDTH-1:0] bram_addr_q;
  logic [XLEN-1:0]       bram_din_q;

  logic [LANES-1:0]      st_we;
  logic [31:0]           st_din;
  logic                  misalign;
  logic [31:0]           ld_data;
  logic                  accept;
  logic                  unused_addr_bits;

  assign accept           = bus.req_valid && req_ready_q;
  assign unused_addr_bits = ^bus.req_addr[31:ADDR_WIDTH+2];

  bram_lsu_align u_align (
    .req_size    (bus.req_size),
    .req_addr_lo (bus.req_addr[1:0]),
    .req_wdata   (bus.req_wdata),
    .st_we       (st_we),
    .st_din      (st_din),
    .misalign    (misalign),
    .ld_size     (ld_size_q),
    .ld_addr_lo  (ld_addr_lo_q),
    .ld_unsigned (ld_unsigned_q),
    .ld_dout     (bus.bram_dout),
    .ld_data     (ld_data)
  );

  // Request/response FSM; owns every registered output, including the BRAM
  // strobes, so that reset drops them asynchronously.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      req_ready_q   <= 1'b0;
      is_store      <= 1'b0;
      ld_size_q     <= SIZE_BYTE;
      ld_addr_lo_q  <= '0;
      ld_unsigned_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      bram_en_q     <= 1'b0;
      bram_we_q     <= '0;
      bram_addr_q   <= '0;
      bram_din_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q   <= 1'b0;
            is_store      <= bus.req_we;
            ld_size_q     <= bus.req_size;
            ld_addr_lo_q  <= bus.req_addr[1:0];
            ld_unsigned_q <= bus.req_unsigned;
            if (misalign) begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_err_q   <= 1'b1;
            end else begin
              state       <= ST_ISSUE;
              bram_en_q   <= 1'b1;
              bram_we_q   <= bus.req_we ? st_we : '0;
              bram_addr_q <= bus.req_addr[ADDR_WIDTH+1:2];
              bram_din_q  <= st_din;
            end
          end
        end
        ST_ISSUE: begin
          bram_en_q <= 1'b0;
          bram_we_q <= '0;
          if (is_store) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end else begin
            state    <= ST_WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= ld_data;
            rsp_err_q   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.bram_en    = bram_en_q;
  assign bus.bram_we    = bram_we_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_din   = bram_din_q;
  assign bus.bram_regce = (READ_LATENCY == 2);
  assign bus.bram_rst   = 1'b0;

endmodule
